// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and default divisor helper
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MIN_DIV        = 2;

  // Clocks per oversample period as a fixed-point value with frac_w fractional bits, truncated.
  function automatic longint unsigned uart_default_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input int unsigned     os,
    input int unsigned     frac_w
  );
    return (clk_hz << frac_w) / (baud * longint'(os));
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// rtl/uart_frac_div.sv - one fractional-N divider channel (period counter + phase accumulator)
module uart_frac_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  cur_int,
  input  logic [FRAC_W-1:0] cur_frac,
  output logic              wrap
);

  logic [DIV_W-1:0]  cnt_q, cnt_d, last_cnt;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  // wrap is the terminal-count cycle; the top also uses it to time pending divisor loads.
  // >= rather than == keeps the channel sane if cur_int shrinks below a running count.
  always_comb begin
    last_cnt = cur_int - DIV_W'(1) + DIV_W'(carry_q);
    wrap     = en && !clr && (cnt_q >= last_cnt);
    cnt_d    = cnt_q + DIV_W'(1);
    acc_d    = acc_q;
    carry_d  = carry_q;
    if (!en || clr) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (wrap) begin
      cnt_d              = '0;
      {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, cur_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional-N UART baud generator with TX bit tick and resyncable RX oversample tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              rx_resync,
  output logic              tx_tick,
  output logic              rx_os_tick,
  output logic              rx_mid_tick
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam longint unsigned DEF_TOTAL =
    uart_default_div(64'(CLK_HZ), 64'(DEFAULT_BAUD), OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_TOTAL >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_TOTAL);

  logic [DIV_W-1:0]  cur_int_q, cur_int_d, pend_int_q, pend_int_d, load_int;
  logic [FRAC_W-1:0] cur_frac_q, cur_frac_d, pend_frac_q, pend_frac_d;
  logic              pend_vld_q, pend_vld_d;
  logic [PH_W-1:0]   tx_ph_q, tx_ph_d, rx_ph_q, rx_ph_d;
  logic              tx_tick_q, tx_tick_d, rx_os_q, rx_os_d, rx_mid_q, rx_mid_d;
  logic              tx_wrap, rx_wrap;

  uart_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_div (
    .clk(clk), .rst(rst), .en(en), .clr(1'b0),
    .cur_int(cur_int_q), .cur_frac(cur_frac_q), .wrap(tx_wrap)
  );

  uart_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_div (
    .clk(clk), .rst(rst), .en(en), .clr(rx_resync),
    .cur_int(cur_int_q), .cur_frac(cur_frac_q), .wrap(rx_wrap)
  );

  always_comb begin
    load_int    = (div_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_int;
    cur_int_d   = cur_int_q;
    cur_frac_d  = cur_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_vld_d  = pend_vld_q;
    tx_ph_d     = tx_ph_q;
    rx_ph_d     = rx_ph_q;
    tx_tick_d   = 1'b0;
    rx_os_d     = 1'b0;
    rx_mid_d    = 1'b0;
    if (!en) begin
      tx_ph_d = '0;
      rx_ph_d = '0;
      if (div_load) begin
        cur_int_d  = load_int;
        cur_frac_d = div_frac;
      end
    end else begin
      // Divisor changes only land on a TX wrap so no tick period is ever cut short.
      if (tx_wrap) begin
        tx_ph_d   = tx_ph_q + PH_W'(1);
        tx_tick_d = (tx_ph_q == PH_W'(OVERSAMPLE - 1));
        if (div_load) begin
          cur_int_d  = load_int;
          cur_frac_d = div_frac;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          cur_int_d  = pend_int_q;
          cur_frac_d = pend_frac_q;
          pend_vld_d = 1'b0;
        end
      end else if (div_load) begin
        pend_int_d  = load_int;
        pend_frac_d = div_frac;
        pend_vld_d  = 1'b1;
      end
      if (rx_resync) begin
        rx_ph_d = '0;
      end else if (rx_wrap) begin
        rx_ph_d  = rx_ph_q + PH_W'(1);
        rx_os_d  = 1'b1;
        rx_mid_d = (rx_ph_q == PH_W'(OVERSAMPLE / 2 - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_int_q   <= DEF_INT;
      cur_frac_q  <= DEF_FRAC;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_vld_q  <= 1'b0;
      tx_ph_q     <= '0;
      rx_ph_q     <= '0;
      tx_tick_q   <= 1'b0;
      rx_os_q     <= 1'b0;
      rx_mid_q    <= 1'b0;
    end else begin
      cur_int_q   <= cur_int_d;
      cur_frac_q  <= cur_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_vld_q  <= pend_vld_d;
      tx_ph_q     <= tx_ph_d;
      rx_ph_q     <= rx_ph_d;
      tx_tick_q   <= tx_tick_d;
      rx_os_q     <= rx_os_d;
      rx_mid_q    <= rx_mid_d;
    end
  end

  assign tx_tick     = tx_tick_q;
  assign rx_os_tick  = rx_os_q;
  assign rx_mid_tick = rx_mid_q;

endmodule
